// File: rtl/page_sel.sv
// Front-panel page controller: debounces 20 active-low buttons, keeps a sticky
// page selection with optional auto-scroll, and drives active-low page selects.
module page_sel #(
    parameter int          DEB_CYCLES   = 50000,
    parameter int          SCROLL_TICKS = 500,
    parameter logic [19:0] PAGE_MASK    = 20'h3FFF8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] btn_n,
    input  logic        auto_en,
    output logic [19:0] sel_n,
    output logic [4:0]  page,
    output logic        tick
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);
    localparam logic [SW-1:0] SCR_MAX   = SW'(SCROLL_TICKS - 1);
    localparam logic [4:0]    HOME_PAGE = 5'd31;

    typedef enum logic [1:0] {
        S_HOME   = 2'd0,
        S_HOLD   = 2'd1,
        S_SCROLL = 2'd2
    } state_t;

    function automatic logic [4:0] lowest_set(input logic [19:0] v);
        logic [4:0] idx;
        idx = HOME_PAGE;
        for (int i = 19; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    localparam logic [4:0] FIRST_PAGE = lowest_set(PAGE_MASK);

    // First enabled page strictly above p, wrapping to the lowest enabled page.
    function automatic logic [4:0] next_enabled(input logic [4:0] p);
        logic [4:0] idx;
        logic       found;
        idx   = FIRST_PAGE;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!found && (i > int'(p)) && PAGE_MASK[i]) begin
                idx   = 5'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    logic [19:0]   r_sync1, r_sync2;
    logic [19:0]   r_hist0, r_hist1;
    logic [19:0]   r_pressed;
    logic [19:0]   r_evt;
    logic [DW-1:0] r_div;
    logic          r_tick;
    logic          w_wrap;
    logic [19:0]   w_all_low, w_all_high, w_pressed_nxt, w_rise;

    // The incoming sample plus the two previous ones form the 3-deep history.
    assign w_wrap        = (r_div == DEB_MAX);
    assign w_all_low     = ~(r_hist1 | r_hist0 | r_sync2);
    assign w_all_high    = r_hist1 & r_hist0 & r_sync2;
    assign w_pressed_nxt = (r_pressed | w_all_low) & ~w_all_high;
    assign w_rise        = w_pressed_nxt & ~r_pressed & PAGE_MASK;

    // NOTE: reset is synchronous, so it is just the first branch of the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_hist0   <= '1;
            r_hist1   <= '1;
            r_pressed <= '0;
            r_evt     <= '0;
            r_div     <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            r_div   <= w_wrap ? '0 : r_div + 1'b1;
            r_tick  <= w_wrap;
            if (w_wrap) begin
                r_hist0   <= r_sync2;
                r_hist1   <= r_hist0;
                r_pressed <= w_pressed_nxt;
                r_evt     <= w_rise;
            end else begin
                r_evt     <= '0;
            end
        end
    end

    state_t        r_state, w_state_nxt;
    logic [4:0]    r_page, w_page_nxt;
    logic [SW-1:0] r_scnt, w_scnt_nxt;
    logic [19:0]   r_sel_n, w_sel_nxt;
    logic          w_evt_any;
    logic [4:0]    w_evt_idx;

    assign w_evt_any = |r_evt;
    assign w_evt_idx = lowest_set(r_evt);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_page_nxt  = r_page;
        w_scnt_nxt  = r_scnt;
        case (r_state)
            S_HOME: begin
                if ((PAGE_MASK != '0) && auto_en) begin
                    w_state_nxt = S_SCROLL;
                    w_page_nxt  = w_evt_any ? w_evt_idx : FIRST_PAGE;
                    w_scnt_nxt  = '0;
                end else if (w_evt_any) begin
                    w_state_nxt = S_HOLD;
                    w_page_nxt  = w_evt_idx;
                end
            end
            S_HOLD: begin
                if (auto_en) begin
                    w_state_nxt = S_SCROLL;
                    w_scnt_nxt  = '0;
                    if (w_evt_any) w_page_nxt = w_evt_idx;
                end else if (w_evt_any) begin
                    if (w_evt_idx == r_page) begin
                        w_state_nxt = S_HOME;
                        w_page_nxt  = HOME_PAGE;
                    end else begin
                        w_page_nxt  = w_evt_idx;
                    end
                end
            end
            S_SCROLL: begin
                if (!auto_en) begin
                    w_state_nxt = S_HOLD;
                    w_scnt_nxt  = '0;
                    if (w_evt_any) w_page_nxt = w_evt_idx;
                end else if (w_evt_any) begin
                    w_page_nxt = w_evt_idx;
                    w_scnt_nxt = '0;
                end else if (r_tick) begin
                    if (r_scnt == SCR_MAX) begin
                        w_page_nxt = next_enabled(r_page);
                        w_scnt_nxt = '0;
                    end else begin
                        w_scnt_nxt = r_scnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_HOME;
                w_page_nxt  = HOME_PAGE;
                w_scnt_nxt  = '0;
            end
        endcase

        for (int i = 0; i < 20; i++) begin
            w_sel_nxt[i] = !((w_state_nxt != S_HOME) && (w_page_nxt == 5'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_HOME;
            r_page  <= HOME_PAGE;
            r_scnt  <= '0;
            r_sel_n <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_page  <= w_page_nxt;
            r_scnt  <= w_scnt_nxt;
            r_sel_n <= w_sel_nxt;
        end
    end

    assign sel_n = r_sel_n;
    assign page  = r_page;
    assign tick  = r_tick;

endmodule
